// File: rtl/foc_seq_pkg.sv
// Shared widths and state encoding for the torque sequencer slice.
package foc_seq_pkg;

    localparam int IQ_W   = 16;
    localparam int HOLD_W = 24;
    localparam int OC_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_POS  = 3'd1,
        ST_HOLD_POS  = 3'd2,
        ST_RAMP_NEG  = 3'd3,
        ST_HOLD_NEG  = 3'd4,
        ST_RAMP_ZERO = 3'd5,
        ST_FAULT     = 3'd6
    } seq_state_t;

endpackage

// File: rtl/iq_ramp_step.sv
// One ramp step: moves cur toward target by at most step, never overshooting.
// Arithmetic is one bit wider than the operands so +/-full-scale plus a step
// cannot wrap before the clamp compare.
module iq_ramp_step
    import foc_seq_pkg::*;
(
    input  logic signed [IQ_W-1:0] cur,
    input  logic signed [IQ_W-1:0] target,
    input  logic        [IQ_W-1:0] step,
    output logic signed [IQ_W-1:0] nxt
);

    logic signed [IQ_W:0] cur_x;
    logic signed [IQ_W:0] tgt_x;
    logic signed [IQ_W:0] step_x;
    logic signed [IQ_W:0] up;
    logic signed [IQ_W:0] dn;

    assign cur_x  = {cur[IQ_W-1], cur};
    assign tgt_x  = {target[IQ_W-1], target};
    assign step_x = {1'b0, step};
    assign up     = cur_x + step_x;
    assign dn     = cur_x - step_x;

    // Take the full step unless it would reach or pass the target.
    always_comb begin
        nxt = target;
        if (cur_x < tgt_x) begin
            if (up < tgt_x) nxt = up[IQ_W-1:0];
        end else if (cur_x > tgt_x) begin
            if (dn > tgt_x) nxt = dn[IQ_W-1:0];
        end
    end

endmodule

// File: rtl/torque_sequencer.sv
// Alternating q-axis torque profile sequencer for the FOC core.
// Optional overcurrent trip is built only when TORQUE_SEQ_OC_EN is defined;
// otherwise fault is tied low and the FAULT state is unreachable.
//
// state      | meaning
// -----------+--------------------------------------------------
// IDLE       | iq_aim held at 0, waiting for enable && init_done
// RAMP_POS   | stepping iq_aim toward +IQ_AMP
// HOLD_POS   | holding +IQ_AMP for HOLD_TICKS ticks
// RAMP_NEG   | stepping iq_aim toward -IQ_AMP
// HOLD_NEG   | holding -IQ_AMP for HOLD_TICKS ticks
// RAMP_ZERO  | enable dropped, stepping iq_aim back to 0
// FAULT      | overcurrent latched, iq_aim forced to 0
module torque_sequencer
    import foc_seq_pkg::*;
#(
    parameter logic signed [IQ_W-1:0]   IQ_AMP     = 16'sd200,
    parameter logic        [IQ_W-1:0]   RAMP_STEP  = 16'd4,
    parameter logic        [HOLD_W-1:0] HOLD_TICKS = 24'd9000,
    parameter logic        [IQ_W-1:0]   OC_LIMIT   = 16'd1500,
    parameter logic        [OC_W-1:0]   OC_COUNT   = 8'd16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   enable,
    input  logic                   init_done,
    input  logic                   en_idq,
    input  logic signed [IQ_W-1:0] iq,
    input  logic                   fault_clr,
    output logic signed [IQ_W-1:0] iq_aim,
    output logic signed [IQ_W-1:0] id_aim,
    output logic                   fault,
    output logic [2:0]             state
);

    seq_state_t             st, st_nxt, seq_st;
    logic signed [IQ_W-1:0] iq_aim_r, iq_aim_nxt, seq_iq;
    logic signed [IQ_W-1:0] target, ramp_val;
    logic [HOLD_W-1:0]      hold_cnt, hold_nxt, seq_hold;

    assign iq_aim = iq_aim_r;
    assign id_aim = '0;
    assign state  = st;

    iq_ramp_step u_ramp (
        .cur    (iq_aim_r),
        .target (target),
        .step   (RAMP_STEP),
        .nxt    (ramp_val)
    );

    // Ramp target for the current state.
    always_comb begin
        target = '0;
        case (st)
            ST_RAMP_POS: target = IQ_AMP;
            ST_RAMP_NEG: target = -IQ_AMP;
            default:     target = '0;
        endcase
    end

    // Normal profile sequencing, ignoring overcurrent.
    always_comb begin
        seq_st   = st;
        seq_iq   = iq_aim_r;
        seq_hold = hold_cnt;
        if (!init_done) begin
            seq_st   = ST_IDLE;
            seq_iq   = '0;
            seq_hold = '0;
        end else if (en_idq) begin
            case (st)
                ST_IDLE: begin
                    if (enable) begin
                        seq_st   = ST_RAMP_POS;
                        seq_hold = '0;
                    end
                end
                ST_RAMP_POS, ST_RAMP_NEG: begin
                    if (!enable) begin
                        seq_st = ST_RAMP_ZERO;
                    end else begin
                        seq_iq = ramp_val;
                        if (ramp_val == target) begin
                            seq_st   = (st == ST_RAMP_POS) ? ST_HOLD_POS : ST_HOLD_NEG;
                            seq_hold = '0;
                        end
                    end
                end
                ST_HOLD_POS, ST_HOLD_NEG: begin
                    if (!enable) begin
                        seq_st = ST_RAMP_ZERO;
                    end else if (hold_cnt == HOLD_TICKS - 24'd1) begin
                        seq_st   = (st == ST_HOLD_POS) ? ST_RAMP_NEG : ST_RAMP_POS;
                        seq_hold = '0;
                    end else begin
                        seq_hold = hold_cnt + 24'd1;
                    end
                end
                ST_RAMP_ZERO: begin
                    seq_iq = ramp_val;
                    if (ramp_val == '0) seq_st = ST_IDLE;
                end
                default: begin
                    seq_st   = ST_IDLE;
                    seq_iq   = '0;
                    seq_hold = '0;
                end
            endcase
        end
    end

`ifdef TORQUE_SEQ_OC_EN
    logic            fault_r, fault_nxt;
    logic [OC_W-1:0] oc_cnt, oc_nxt;
    logic [IQ_W:0]   iq_abs;
    logic            oc_over;

    assign iq_abs  = iq[IQ_W-1] ? (17'd0 - {iq[IQ_W-1], iq}) : {1'b0, iq};
    assign oc_over = iq_abs > {1'b0, OC_LIMIT};
    assign fault   = fault_r;

    // Overcurrent supervision layered over the profile; FAULT wins over everything.
    always_comb begin
        st_nxt     = seq_st;
        iq_aim_nxt = seq_iq;
        hold_nxt   = seq_hold;
        fault_nxt  = fault_r;
        oc_nxt     = oc_cnt;
        if (st == ST_FAULT) begin
            st_nxt     = ST_FAULT;
            iq_aim_nxt = '0;
            hold_nxt   = '0;
            if (fault_clr && !enable) begin
                st_nxt    = ST_IDLE;
                fault_nxt = 1'b0;
                oc_nxt    = '0;
            end
        end else if (en_idq) begin
            if (oc_over) begin
                if (oc_cnt >= OC_COUNT - 8'd1) begin
                    st_nxt     = ST_FAULT;
                    iq_aim_nxt = '0;
                    hold_nxt   = '0;
                    fault_nxt  = 1'b1;
                    oc_nxt     = OC_COUNT;
                end else begin
                    oc_nxt = oc_cnt + 8'd1;
                end
            end else begin
                oc_nxt = '0;
            end
        end
    end

    // Fault flag and overcurrent run-length counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fault_r <= 1'b0;
            oc_cnt  <= '0;
        end else begin
            fault_r <= fault_nxt;
            oc_cnt  <= oc_nxt;
        end
    end
`else
    logic unused_oc;

    assign unused_oc  = ^{iq, fault_clr, OC_LIMIT, OC_COUNT};
    assign fault      = 1'b0;
    assign st_nxt     = seq_st;
    assign iq_aim_nxt = seq_iq;
    assign hold_nxt   = seq_hold;
`endif

    // State, target and hold counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st       <= ST_IDLE;
            iq_aim_r <= '0;
            hold_cnt <= '0;
        end else begin
            st       <= st_nxt;
            iq_aim_r <= iq_aim_nxt;
            hold_cnt <= hold_nxt;
        end
    end

endmodule

// File: tb/tb_torque_sequencer.sv
// Self-checking bench for torque_sequencer: a step-4 instance runs every
// scenario, a step-7 instance on the same stimulus checks the ramp clamp.
// Overcurrent scenarios depend on TORQUE_SEQ_OC_EN.
module tb_torque_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic        init_done;
    logic        en_idq;
    logic signed [15:0] iq;
    logic        fault_clr;
    logic signed [15:0] iq_aim, id_aim, iq_aim7, id_aim7;
    logic        fault, fault7;
    logic [2:0]  state, state7;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string tag;
        int    iq;
        int    st;
        int    flt;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb7_q[$];

    always #5 clk = ~clk;

    torque_sequencer #(
        .IQ_AMP(16'sd200), .RAMP_STEP(16'd4), .HOLD_TICKS(24'd10),
        .OC_LIMIT(16'd1500), .OC_COUNT(8'd4)
    ) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .init_done(init_done),
        .en_idq(en_idq), .iq(iq), .fault_clr(fault_clr),
        .iq_aim(iq_aim), .id_aim(id_aim), .fault(fault), .state(state)
    );

    torque_sequencer #(
        .IQ_AMP(16'sd200), .RAMP_STEP(16'd7), .HOLD_TICKS(24'd10),
        .OC_LIMIT(16'd1500), .OC_COUNT(8'd4)
    ) dut7 (
        .clk(clk), .rstn(rstn), .enable(enable), .init_done(init_done),
        .en_idq(en_idq), .iq(iq), .fault_clr(fault_clr),
        .iq_aim(iq_aim7), .id_aim(id_aim7), .fault(fault7), .state(state7)
    );

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input string tag, input int e_iq, input int e_st, input int e_flt);
        exp_t e;
        e.tag = tag; e.iq = e_iq; e.st = e_st; e.flt = e_flt;
        sb_q.push_back(e);
    endtask

    task automatic push_exp7(input string tag, input int e_iq, input int e_st);
        exp_t e;
        e.tag = tag; e.iq = e_iq; e.st = e_st; e.flt = 0;
        sb7_q.push_back(e);
    endtask

    // One control tick every 8 clk; outputs compared one clk after the tick edge.
    task automatic pulse();
        exp_t e;
        @(negedge clk); en_idq = 1'b1;
        @(negedge clk); en_idq = 1'b0;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({e.tag, ".iq"},  int'(iq_aim), e.iq);
            chk({e.tag, ".st"},  int'(state),  e.st);
            chk({e.tag, ".flt"}, int'(fault),  e.flt);
        end
        if (sb7_q.size() > 0) begin
            e = sb7_q.pop_front();
            chk({e.tag, ".iq7"}, int'(iq_aim7), e.iq);
            chk({e.tag, ".st7"}, int'(state7),  e.st);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic ramp_up_and_hold(input string pfx);
        for (int k = 1; k <= 50; k++) begin
            push_exp($sformatf("%s_up%0d", pfx, k), 4 * k, (k == 50) ? 2 : 1, 0);
            pulse();
        end
        for (int h = 1; h <= 10; h++) begin
            push_exp($sformatf("%s_hold%0d", pfx, h), 200, (h == 10) ? 3 : 2, 0);
            pulse();
        end
    endtask

    initial begin
        rstn = 1'b0; enable = 1'b0; init_done = 1'b0; en_idq = 1'b0;
        iq = '0; fault_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.iq", int'(iq_aim), 0);
        chk("rst.st", int'(state), 0);
        chk("rst.flt", int'(fault), 0);
        chk("rst.id", int'(id_aim), 0);
        rstn = 1'b1;

        // Full profile; step-7 instance checks the clamped approach to 200.
        enable = 1'b1; init_done = 1'b1;
        push_exp("start", 0, 1, 0);
        push_exp7("start", 0, 1);
        for (int k = 1; k <= 29; k++)
            push_exp7($sformatf("clamp%0d", k), (7 * k > 200) ? 200 : 7 * k, (7 * k >= 200) ? 2 : 1);
        pulse();
        ramp_up_and_hold("prof");
        for (int r = 1; r <= 100; r++) begin
            push_exp($sformatf("neg%0d", r), 200 - 4 * r, (r == 100) ? 4 : 3, 0);
            pulse();
        end
        for (int h = 1; h <= 3; h++) begin
            push_exp($sformatf("nhold%0d", h), -200, 4, 0);
            pulse();
        end
        chk("id_aim_run", int'(id_aim), 0);

        // Asynchronous reset in HOLD_NEG.
        @(negedge clk); rstn = 1'b0;
        #1;
        chk("arst.iq", int'(iq_aim), 0);
        chk("arst.st", int'(state), 0);
        @(negedge clk); rstn = 1'b1;

        // Disable at iq_aim=100, re-enable mid ramp-down has no effect.
        push_exp("dis_start", 0, 1, 0);
        pulse();
        for (int k = 1; k <= 25; k++) begin
            push_exp($sformatf("dis_up%0d", k), 4 * k, 1, 0);
            pulse();
        end
        enable = 1'b0;
        push_exp("dis_edge", 100, 5, 0);
        pulse();
        for (int j = 1; j <= 25; j++) begin
            if (j == 11) enable = 1'b1;
            push_exp($sformatf("dis_dn%0d", j), 100 - 4 * j, (j == 25) ? 0 : 5, 0);
            pulse();
        end
        push_exp("restart", 0, 1, 0);
        pulse();
        ramp_up_and_hold("re");
        for (int r = 1; r <= 3; r++) begin
            push_exp($sformatf("re_neg%0d", r), 200 - 4 * r, 3, 0);
            pulse();
        end

        // init_done drop without any tick.
        @(negedge clk); init_done = 1'b0;
        @(negedge clk);
        chk("idrop.iq", int'(iq_aim), 0);
        chk("idrop.st", int'(state), 0);
        init_done = 1'b1; enable = 1'b0;
        push_exp("idrop_idle", 0, 0, 0);
        pulse();

`ifdef TORQUE_SEQ_OC_EN
        enable = 1'b1;
        iq = 16'sd1501;
        push_exp("oc_a1", 0, 1, 0);  pulse();
        push_exp("oc_a2", 4, 1, 0);  pulse();
        push_exp("oc_a3", 8, 1, 0);  pulse();
        iq = 16'sd0;
        push_exp("oc_gap1", 12, 1, 0); pulse();
        iq = 16'sd1501;
        push_exp("oc_b1", 16, 1, 0); pulse();
        push_exp("oc_b2", 20, 1, 0); pulse();
        push_exp("oc_b3", 24, 1, 0); pulse();
        iq = 16'sd0;
        push_exp("oc_gap2", 28, 1, 0); pulse();
        iq = -16'sd1600;
        push_exp("oc_n1", 32, 1, 0); pulse();
        push_exp("oc_n2", 36, 1, 0); pulse();
        push_exp("oc_n3", 40, 1, 0); pulse();
        push_exp("oc_trip", 0, 6, 1); pulse();
        iq = 16'sd0;
        @(negedge clk); fault_clr = 1'b1;
        @(negedge clk); fault_clr = 1'b0;
        chk("clr_en.st", int'(state), 6);
        chk("clr_en.flt", int'(fault), 1);
        push_exp("fault_hold", 0, 6, 1); pulse();
        enable = 1'b0;
        @(negedge clk); fault_clr = 1'b1;
        @(negedge clk); fault_clr = 1'b0;
        chk("clr.st", int'(state), 0);
        chk("clr.flt", int'(fault), 0);
        push_exp("post_clr", 0, 0, 0); pulse();
`else
        enable = 1'b0;
        iq = 16'sd32767;
        for (int t = 1; t <= 100; t++) begin
            if (t == 50) fault_clr = 1'b1;
            push_exp($sformatf("nooc%0d", t), 0, 0, 0);
            pulse();
            fault_clr = 1'b0;
        end
        iq = 16'sd0;
`endif

        chk("sb_drain", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
